activation_pipeline: RTL and testbench



---
 rtl/act_pkg.sv | 52 +++++
 rtl/act_fifo.sv | 63 ++++++
 rtl/activation_pipeline.sv | 210 +++++++++++++++++++++
 tb/tb_activation_pipeline.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared types, constants and arithmetic helpers for the activation pipeline.
package act_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } act_state_t;

    localparam logic signed [7:0] INT8_MIN = 8'sh80;
    localparam logic signed [7:0] INT8_MAX = 8'sh7F;

    // Signed 32-bit add that clamps to the representable range instead of wrapping.
    function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        logic signed [32:0] sum;
        sum = $signed({a[31], a}) + $signed({b[31], b});
        if (sum[32] != sum[31]) begin
            return sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

    // Round-half-up arithmetic right shift, add zero point, clamp to int8.
    // 34 bits hold the worst case of max int32 plus the rounding constant.
    function automatic logic [7:0] requant_int8(input logic signed [31:0] val,
                                                input logic [4:0]         shift,
                                                input logic signed [7:0]  zp);
        logic signed [33:0] t;
        logic signed [33:0] rnd;
        logic signed [33:0] zp_ext;
        t      = {{2{val[31]}}, val};
        zp_ext = {{26{zp[7]}}, zp};
        if (shift != 5'd0) begin
            rnd = 34'sd1 <<< (shift - 5'd1);
            t   = (t + rnd) >>> shift;
        end else begin
            rnd = 34'sd0;
        end
        t = t + zp_ext;
        if (t > 34'sd127) begin
            return INT8_MAX;
        end else if (t < -34'sd128) begin
            return INT8_MIN;
        end else begin
            return t[7:0];
        end
    endfunction

endpackage

// File: rtl/act_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on data_o while not empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle;
// otherwise it is discarded and drop_o flags it.
module act_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);
    import act_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign full_s    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_s || do_pop_s);
    assign drop_o    = push_i && full_s && !do_pop_s;
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/activation_pipeline.sv
// Bias / ReLU / requant pipeline over the accumulator's three result columns,
// packing each row into a 24-bit word written to the unified buffer.
// The input side can never stall; a FIFO absorbs write backpressure.
module activation_pipeline #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic signed [31:0] acc_col0_in,
    input  logic signed [31:0] acc_col1_in,
    input  logic signed [31:0] acc_col2_in,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [7:0]         cfg_row_count,
    input  logic               cfg_relu,
    input  logic [4:0]         cfg_shift,
    input  logic signed [7:0]  cfg_zero_point,
    input  logic signed [31:0] cfg_bias0,
    input  logic signed [31:0] cfg_bias1,
    input  logic signed [31:0] cfg_bias2,
    output logic               ub_wr_en,
    input  logic               ub_wr_ready,
    output logic [ADDR_W-1:0]  ub_wr_addr,
    output logic [23:0]        ub_wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow_err
);
    import act_pkg::*;

    localparam int FAW = $clog2(FIFO_DEPTH);

    act_state_t         state_q, state_d;
    logic [7:0]         rows_q, rows_d;
    logic [7:0]         cnt_q;
    logic               relu_q;
    logic [4:0]         shift_q;
    logic signed [7:0]  zp_q;
    logic signed [31:0] bias_q [3];
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ovf_q, ovf_d;

    logic signed [31:0] acc_s [3];
    logic               accept_s;
    logic               latch_s;
    logic               extra_s;
    logic               drain_empty_s;

    logic               s1_v_q, s2_v_q, s3_v_q;
    logic signed [31:0] s1_c_q [3];
    logic signed [31:0] s2_c_q [3];
    logic [23:0]        s3_data_q;

    logic [23:0]        fifo_data_s;
    logic               fifo_empty_s;
    logic [FAW:0]       fifo_count_s;
    logic               fifo_drop_s;
    logic               pop_s;

    assign acc_s[0] = acc_col0_in;
    assign acc_s[1] = acc_col1_in;
    assign acc_s[2] = acc_col2_in;

    assign pop_s = !fifo_empty_s && ub_wr_ready;

    // Everything has left the pipeline once this cycle's pop (if any) completes,
    // so DONE lands exactly one cycle after the final write.
    assign drain_empty_s = !s1_v_q && !s2_v_q && !s3_v_q &&
                           (fifo_empty_s ||
                            ((fifo_count_s == {{FAW{1'b0}}, 1'b1}) && pop_s));

    // Next-state, row acceptance, address and sticky overflow logic.
    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        accept_s = 1'b0;
        latch_s  = 1'b0;
        extra_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_s = 1'b1;
                    rows_d  = 8'd0;
                    state_d = (cfg_row_count == 8'd0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (valid_in && (rows_q < cnt_q)) begin
                    accept_s = 1'b1;
                    rows_d   = rows_q + 8'd1;
                end else if (valid_in) begin
                    extra_s = 1'b1;
                end else begin
                    rows_d = rows_q;
                end
                state_d = (rows_d == cnt_q) ? DRAIN : RUN;
            end
            DRAIN: begin
                extra_s = valid_in;
                state_d = drain_empty_s ? DONE : DRAIN;
            end
            DONE: begin
                extra_s = valid_in;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (latch_s) begin
            addr_d = cfg_base_addr;
        end else if (pop_s) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
        end

        if (latch_s) begin
            ovf_d = 1'b0;
        end else if (fifo_drop_s || extra_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state, job configuration, address counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rows_q  <= 8'd0;
            cnt_q   <= 8'd0;
            relu_q  <= 1'b0;
            shift_q <= 5'd0;
            zp_q    <= 8'sd0;
            for (int i = 0; i < 3; i++) begin
                bias_q[i] <= 32'sd0;
            end
            addr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            if (latch_s) begin
                cnt_q     <= cfg_row_count;
                relu_q    <= cfg_relu;
                shift_q   <= cfg_shift;
                zp_q      <= cfg_zero_point;
                bias_q[0] <= cfg_bias0;
                bias_q[1] <= cfg_bias1;
                bias_q[2] <= cfg_bias2;
            end
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Three-stage datapath: bias (S1), activation (S2), requantize and pack (S3).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s3_data_q <= 24'd0;
            for (int i = 0; i < 3; i++) begin
                s1_c_q[i] <= 32'sd0;
                s2_c_q[i] <= 32'sd0;
            end
        end else begin
            s1_v_q <= accept_s;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            for (int i = 0; i < 3; i++) begin
                s1_c_q[i] <= sat_add32(acc_s[i], bias_q[i]);
                s2_c_q[i] <= (relu_q && s1_c_q[i][31]) ? 32'sd0 : s1_c_q[i];
            end
            s3_data_q <= {requant_int8(s2_c_q[2], shift_q, zp_q),
                          requant_int8(s2_c_q[1], shift_q, zp_q),
                          requant_int8(s2_c_q[0], shift_q, zp_q)};
        end
    end

    act_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s3_v_q),
        .pop_i   (pop_s),
        .data_i  (s3_data_q),
        .data_o  (fifo_data_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s),
        .drop_o  (fifo_drop_s)
    );

    assign ub_wr_en     = !fifo_empty_s;
    assign ub_wr_data   = fifo_data_s;
    assign ub_wr_addr   = addr_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_activation_pipeline.sv
// Self-checking bench for activation_pipeline: table-driven single-row jobs
// plus hand-written multi-cycle sequences, with a write scoreboard.
module tb_activation_pipeline;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic signed [31:0] acc_col0_in = '0, acc_col1_in = '0, acc_col2_in = '0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  cfg_base_addr = '0;
    logic [7:0]         cfg_row_count = '0;
    logic               cfg_relu = 1'b0;
    logic [4:0]         cfg_shift = '0;
    logic signed [7:0]  cfg_zero_point = '0;
    logic signed [31:0] cfg_bias0 = '0, cfg_bias1 = '0, cfg_bias2 = '0;
    logic               ub_wr_en;
    logic               ub_wr_ready = 1'b1;
    logic [ADDR_W-1:0]  ub_wr_addr;
    logic [23:0]        ub_wr_data;
    logic               busy, done, overflow_err;

    activation_pipeline #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .acc_col0_in(acc_col0_in), .acc_col1_in(acc_col1_in), .acc_col2_in(acc_col2_in),
        .start(start), .cfg_base_addr(cfg_base_addr), .cfg_row_count(cfg_row_count),
        .cfg_relu(cfg_relu), .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point),
        .cfg_bias0(cfg_bias0), .cfg_bias1(cfg_bias1), .cfg_bias2(cfg_bias2),
        .ub_wr_en(ub_wr_en), .ub_wr_ready(ub_wr_ready), .ub_wr_addr(ub_wr_addr),
        .ub_wr_data(ub_wr_data), .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          relu;
        int          sh;
        int          zp;
        int          b0, b1, b2;
        int          a0, a1, a2;
        logic [23:0] exp;
    } vec_t;
    vec_t tab [7];

    logic [ADDR_W-1:0] exp_addr;
    int  last_wr_cyc = 0;
    bit  wrote = 1'b0;
    bit  m_relu;
    int  m_sh, m_zp, m_b0, m_b1, m_b2;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference for one column: wide integer arithmetic, clamp, round, clamp.
    function automatic logic [7:0] mdl(int acc, int bias);
        longint v;
        longint one;
        one = 1;
        v = longint'(acc) + longint'(bias);
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        if (v < -64'sd2147483648) v = -64'sd2147483648;
        if (m_relu && v < 0) v = 0;
        if (m_sh > 0) v = (v + (one <<< (m_sh - 1))) >>> m_sh;
        v = v + m_zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic monitor();
        bit                p_stall = 1'b0;
        logic [ADDR_W-1:0] p_addr = '0;
        logic [23:0]       p_data = '0;
        exp_t              e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    chk("hold_en", ub_wr_en, 1);
                    chk("hold_addr", ub_wr_addr, p_addr);
                    chk("hold_data", ub_wr_data, p_data);
                end
                if (ub_wr_en && ub_wr_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write",
                                 ub_wr_addr, ub_wr_data);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_addr", ub_wr_addr, e.addr);
                        chk("wr_data", ub_wr_data, e.data);
                    end
                    last_wr_cyc = cyc;
                    wrote = 1'b1;
                end
                if (done) begin
                    if (wrote) chk("done_after_last_write", cyc, last_wr_cyc + 1);
                    chk("sb_empty_at_done", sb.size(), 0);
                end
                p_stall = ub_wr_en && !ub_wr_ready;
                p_addr  = ub_wr_addr;
                p_data  = ub_wr_data;
            end
        end
    endtask

    task automatic start_job(logic [ADDR_W-1:0] base, logic [7:0] cnt, bit relu,
                             int sh, int zp, int b0, int b1, int b2);
        @(posedge clk); #1;
        cfg_base_addr  = base;
        cfg_row_count  = cnt;
        cfg_relu       = relu;
        cfg_shift      = sh[4:0];
        cfg_zero_point = zp[7:0];
        cfg_bias0 = b0; cfg_bias1 = b1; cfg_bias2 = b2;
        m_relu = relu; m_sh = sh; m_zp = zp; m_b0 = b0; m_b1 = b1; m_b2 = b2;
        exp_addr = base;
        wrote = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: row must be discarded; 1: expect model result; 2: expect given word
    task automatic row(int a0, int a1, int a2, int mode, logic [23:0] word);
        exp_t e;
        valid_in = 1'b1;
        acc_col0_in = a0; acc_col1_in = a1; acc_col2_in = a2;
        if (mode != 0) begin
            e.addr = exp_addr;
            e.data = (mode == 2) ? word : {mdl(a2, m_b2), mdl(a1, m_b1), mdl(a0, m_b0)};
            sb.push_back(e);
            exp_addr = exp_addr + 1'b1;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_done(int max, string name);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_en"},   ub_wr_en, 0);
        chk({tag, "_addr"}, ub_wr_addr, 0);
        chk({tag, "_data"}, ub_wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"},  overflow_err, 0);
    endtask

    initial begin
        tab[0] = '{1'b1, 4,   0,    0, 0, 0,  100, -50, 4000, 24'h7F0006};
        tab[1] = '{1'b0, 0, -10,    0, 0, 0,    5, -200,   0, 24'hF680FB};
        tab[2] = '{1'b0, 4,   0,    0, 0, 0,    0, -50,    0, 24'h00FD00};
        tab[3] = '{1'b0, 24,  0, 2147483647, 0, 0, 10, 0, 0, 24'h00007F};
        tab[4] = '{1'b0, 0,   5,    0, int'(32'h8000_0000), 0, 0, -10, 0, 24'h058005};
        tab[5] = '{1'b0, 1,   0,    0, 0, 0,    3,  -3,   -1, 24'h00FF02};
        tab[6] = '{1'b1, 2,   3,  200, -60, 0, -100, 50,  400, 24'h67031C};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single-row jobs from the table
        for (int i = 0; i < 7; i++) begin
            start_job(8'h10, 8'd1, tab[i].relu, tab[i].sh, tab[i].zp,
                      tab[i].b0, tab[i].b1, tab[i].b2);
            row(tab[i].a0, tab[i].a1, tab[i].a2, 2, tab[i].exp);
            wait_done(40, "done_vec");
            chk("ovf_vec", overflow_err, 0);
        end
        chk("busy_after_done", busy, 0);

        // Zero-row job completes with no writes
        start_job(8'h20, 8'd0, 1'b0, 0, 0, 0, 0, 0);
        wait_done(10, "done_count0");
        chk("busy_count0", busy, 0);

        // Backpressure within FIFO capacity
        ub_wr_ready = 1'b0;
        start_job(8'h10, 8'd4, 1'b0, 2, 1, 7, -9, 300);
        for (int i = 0; i < 4; i++) row(40 * i - 50, 17 * i, -333 * i, 1, 24'h0);
        repeat (8) @(posedge clk);
        #1;
        ub_wr_ready = 1'b1;
        wait_done(40, "done_bp4");
        chk("ovf_bp4", overflow_err, 0);

        // Backpressure overrun: fifth row dropped
        ub_wr_ready = 1'b0;
        start_job(8'h10, 8'd5, 1'b1, 3, -4, 0, 100, -100);
        for (int i = 0; i < 5; i++) row(80 * i, -25 * i, 999, (i < 4) ? 1 : 0, 24'h0);
        repeat (7) @(posedge clk);
        #1;
        ub_wr_ready = 1'b1;
        wait_done(40, "done_bp5");
        chk("ovf_bp5", overflow_err, 1);

        // Row limit: third row arrives after the job has all its rows
        start_job(8'h40, 8'd2, 1'b0, 0, 0, 0, 0, 0);
        row(1, 2, 3, 1, 24'h0);
        row(4, 5, 6, 1, 24'h0);
        row(7, 8, 9, 0, 24'h0);
        wait_done(40, "done_limit");
        chk("ovf_limit", overflow_err, 1);

        // Address wrap; start also clears the sticky flag
        start_job(8'hFF, 8'd2, 1'b0, 1, 2, 0, 0, 0);
        chk("ovf_cleared", overflow_err, 0);
        row(11, -11, 0, 1, 24'h0);
        row(-7, 7, 127, 1, 24'h0);
        wait_done(40, "done_wrap");
        chk("ovf_wrap", overflow_err, 0);

        // Mixed stalls with random data
        start_job(8'h50, 8'd8, 1'b1, 3, -5, 12, -34, 56);
        for (int i = 0; i < 8; i++) begin
            ub_wr_ready = (i % 3 != 2);
            row(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                int'($urandom_range(0, 4000)) - 2000, 1, 24'h0);
        end
        ub_wr_ready = 1'b1;
        wait_done(60, "done_mixed");
        chk("ovf_mixed", overflow_err, 0);

        // Reset with rows sitting in the FIFO
        ub_wr_ready = 1'b0;
        start_job(8'h60, 8'd3, 1'b0, 0, 0, 0, 0, 0);
        row(1, 1, 1, 1, 24'h0);
        row(2, 2, 2, 1, 24'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_en", ub_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ub_wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_no_wr", ub_wr_en, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
